// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice: widths and memory-stage state encoding.
package mips_pkg;
   localparam int MEM_DATA_W = 32;
   localparam int REG_IDX_W  = 5;
   localparam int TIMER_W    = 8;

   typedef enum logic {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;
endpackage

// File: rtl/stage_timer.sv
// Wait-cycle counter for the memory stage; expired flags the last permitted wait cycle.
module stage_timer
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   assign expired_o = (count_q == LAST);

   // Next count: clear wins, then increment until the last wait cycle is reached.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = {TIMER_W{1'b0}};
      end else if (enable_i && !expired_o) begin
         count_d = count_q + TIMER_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {TIMER_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results to writeback and runs blocking load/store
// handshakes with timeout abort.
module mem_stage
   import mips_pkg::*;
#(
   parameter int DATA_W  = MEM_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ExValid,
   input  logic                 ExRegWrite,
   input  logic                 ExMemRead,
   input  logic                 ExMemWrite,
   input  logic [REG_IDX_W-1:0] ExWriteReg,
   input  logic [DATA_W-1:0]    ExAluResult,
   input  logic [DATA_W-1:0]    ExStoreData,
   input  logic                 Flush,
   output logic                 MemReq,
   output logic                 MemWe,
   output logic [DATA_W-1:0]    MemAddr,
   output logic [DATA_W-1:0]    MemWData,
   input  logic                 MemAck,
   input  logic [DATA_W-1:0]    MemRData,
   output logic                 Stall,
   output logic                 RegWrite,
   output logic [REG_IDX_W-1:0] WriteReg,
   output logic [DATA_W-1:0]    WriteData,
   output logic                 BusError
);

   state_e                 state_q;
   logic [DATA_W-1:0]      addr_q;
   logic [DATA_W-1:0]      wdata_q;
   logic                   we_q;
   logic                   load_wr_q;
   logic [REG_IDX_W-1:0]   dest_q;
   logic                   reg_write_q;
   logic [REG_IDX_W-1:0]   wb_reg_q;
   logic [DATA_W-1:0]      wb_data_q;
   logic                   bus_err_q;

   logic accept_s;
   logic is_mem_s;
   logic in_wait_s;
   logic expired_s;

   assign in_wait_s = (state_q == MEM_WAIT);
   assign accept_s  = (state_q == IDLE) && ExValid && !Flush;
   assign is_mem_s  = ExMemRead || ExMemWrite;

   stage_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (!in_wait_s),
      .enable_i  (in_wait_s),
      .expired_o (expired_s)
   );

   // Stage FSM; writeback and memory outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= {DATA_W{1'b0}};
         wdata_q     <= {DATA_W{1'b0}};
         we_q        <= 1'b0;
         load_wr_q   <= 1'b0;
         dest_q      <= {REG_IDX_W{1'b0}};
         reg_write_q <= 1'b0;
         wb_reg_q    <= {REG_IDX_W{1'b0}};
         wb_data_q   <= {DATA_W{1'b0}};
         bus_err_q   <= 1'b0;
      end else begin
         reg_write_q <= 1'b0;
         bus_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept_s && is_mem_s) begin
                  state_q   <= MEM_WAIT;
                  addr_q    <= ExAluResult;
                  wdata_q   <= ExStoreData;
                  we_q      <= ExMemWrite;
                  dest_q    <= ExWriteReg;
                  // Store wins over load; r0 is never written back.
                  load_wr_q <= !ExMemWrite && ExRegWrite &&
                               (ExWriteReg != {REG_IDX_W{1'b0}});
               end else if (accept_s && ExRegWrite &&
                            (ExWriteReg != {REG_IDX_W{1'b0}})) begin
                  reg_write_q <= 1'b1;
                  wb_reg_q    <= ExWriteReg;
                  wb_data_q   <= ExAluResult;
               end
            end
            MEM_WAIT: begin
               if (MemAck) begin
                  state_q <= IDLE;
                  we_q    <= 1'b0;
                  if (load_wr_q) begin
                     reg_write_q <= 1'b1;
                     wb_reg_q    <= dest_q;
                     wb_data_q   <= MemRData;
                  end
               end else if (expired_s) begin
                  state_q   <= IDLE;
                  we_q      <= 1'b0;
                  bus_err_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               we_q    <= 1'b0;
            end
         endcase
      end
   end

   assign MemReq    = in_wait_s;
   assign Stall     = in_wait_s;
   assign MemWe     = we_q;
   assign MemAddr   = addr_q;
   assign MemWData  = wdata_q;
   assign RegWrite  = reg_write_q;
   assign WriteReg  = wb_reg_q;
   assign WriteData = wb_data_q;
   assign BusError  = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk;
   logic          rst_n;
   logic          ExValid, ExRegWrite, ExMemRead, ExMemWrite, Flush;
   logic [4:0]    ExWriteReg;
   logic [DW-1:0] ExAluResult, ExStoreData;
   logic          MemReq, MemWe, MemAck, Stall, RegWrite, BusError;
   logic [DW-1:0] MemAddr, MemWData, MemRData, WriteData;
   logic [4:0]    WriteReg;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit          m_busy, m_we, m_ldwr, m_rw, m_berr;
   int          m_wcnt;
   logic [31:0] m_addr, m_sdata, m_wbdata;
   logic [4:0]  m_dest, m_wbreg;

   mem_stage #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .ExValid(ExValid), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
      .ExMemWrite(ExMemWrite), .ExWriteReg(ExWriteReg), .ExAluResult(ExAluResult),
      .ExStoreData(ExStoreData), .Flush(Flush),
      .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemAck(MemAck), .MemRData(MemRData),
      .Stall(Stall), .RegWrite(RegWrite), .WriteReg(WriteReg),
      .WriteData(WriteData), .BusError(BusError)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one instruction in flight at most; count wait cycles, resolve by ack or timeout.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_busy = 1'b0; m_we = 1'b0; m_ldwr = 1'b0; m_rw = 1'b0; m_berr = 1'b0;
         m_wcnt = 0; m_addr = 32'd0; m_sdata = 32'd0; m_wbdata = 32'd0;
         m_dest = 5'd0; m_wbreg = 5'd0;
      end else begin
         m_rw   = 1'b0;
         m_berr = 1'b0;
         if (m_busy) begin
            m_wcnt = m_wcnt + 1;
            if (MemAck) begin
               m_busy = 1'b0;
               if (m_ldwr) begin
                  m_rw = 1'b1; m_wbreg = m_dest; m_wbdata = MemRData;
               end
            end else if (m_wcnt == TO) begin
               m_busy = 1'b0;
               m_berr = 1'b1;
            end
         end else if (ExValid && !Flush) begin
            if (ExMemRead || ExMemWrite) begin
               m_busy = 1'b1; m_wcnt = 0;
               m_addr = ExAluResult; m_sdata = ExStoreData;
               m_we = ExMemWrite; m_dest = ExWriteReg;
               m_ldwr = !ExMemWrite && ExRegWrite && (ExWriteReg != 5'd0);
            end else if (ExRegWrite && ExWriteReg != 5'd0) begin
               m_rw = 1'b1; m_wbreg = ExWriteReg; m_wbdata = ExAluResult;
            end
         end
      end
   end

   // Compare every cycle on the falling edge.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("Stall",     32'(Stall),     32'(m_busy));
         chk("MemReq",    32'(MemReq),    32'(m_busy));
         chk("BusError",  32'(BusError),  32'(m_berr));
         chk("RegWrite",  32'(RegWrite),  32'(m_rw));
         chk("WriteReg",  32'(WriteReg),  32'(m_wbreg));
         chk("WriteData", WriteData,      m_wbdata);
         if (m_busy) begin
            chk("MemWe",    32'(MemWe), 32'(m_we));
            chk("MemAddr",  MemAddr,    m_addr);
            chk("MemWData", MemWData,   m_sdata);
         end
      end
   end

   task automatic clear_ex();
      ExValid = 1'b0; ExRegWrite = 1'b0; ExMemRead = 1'b0; ExMemWrite = 1'b0;
      ExWriteReg = 5'd0; ExAluResult = 32'd0; ExStoreData = 32'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int req_cnt;
      rst_n = 1'b0; Flush = 1'b0; MemAck = 1'b0; MemRData = 32'd0;
      clear_ex();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_Stall",     32'(Stall),    32'd0);
      chk("rst_MemReq",    32'(MemReq),   32'd0);
      chk("rst_RegWrite",  32'(RegWrite), 32'd0);
      chk("rst_WriteData", WriteData,     32'd0);
      chk("rst_MemAddr",   MemAddr,       32'd0);
      rst_n = 1'b1;

      // ALU op r5 <- 0x1234
      ExValid = 1'b1; ExRegWrite = 1'b1; ExWriteReg = 5'd5; ExAluResult = 32'h1234;
      step(); clear_ex();
      chk("alu_RegWrite",  32'(RegWrite), 32'd1);
      chk("alu_WriteReg",  32'(WriteReg), 32'd5);
      chk("alu_WriteData", WriteData,     32'h1234);
      chk("alu_Stall",     32'(Stall),    32'd0);
      step();
      chk("alu_hold_RegWrite",  32'(RegWrite), 32'd0);
      chk("alu_hold_WriteData", WriteData,     32'h1234);

      // Load r7 from 0x40, ack on 4th wait cycle; next ALU op held behind the stall
      ExValid = 1'b1; ExRegWrite = 1'b1; ExMemRead = 1'b1; ExWriteReg = 5'd7; ExAluResult = 32'h40;
      step();
      ExMemRead = 1'b0; ExWriteReg = 5'd9; ExAluResult = 32'h99;
      req_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         MemAck = (i == 3); MemRData = 32'hCAFEF00D;
         @(negedge clk);
         if (MemReq) req_cnt++;
         step();
      end
      MemAck = 1'b0;
      chk("ld_req_cycles", 32'(req_cnt),  32'd4);
      chk("ld_RegWrite",   32'(RegWrite), 32'd1);
      chk("ld_WriteReg",   32'(WriteReg), 32'd7);
      chk("ld_WriteData",  WriteData,     32'hCAFEF00D);
      step(); clear_ex();
      chk("held_RegWrite",  32'(RegWrite), 32'd1);
      chk("held_WriteReg",  32'(WriteReg), 32'd9);
      chk("held_WriteData", WriteData,     32'h99);

      // Store 0xA5A5A5A5 to 0x80, immediate ack
      ExValid = 1'b1; ExMemWrite = 1'b1; ExAluResult = 32'h80; ExStoreData = 32'hA5A5A5A5;
      step(); clear_ex();
      MemAck = 1'b1;
      chk("st_MemReq",   32'(MemReq), 32'd1);
      chk("st_MemWe",    32'(MemWe),  32'd1);
      chk("st_MemAddr",  MemAddr,     32'h80);
      chk("st_MemWData", MemWData,    32'hA5A5A5A5);
      step();
      MemAck = 1'b0;
      chk("st_MemReq_off",  32'(MemReq),   32'd0);
      chk("st_RegWrite",    32'(RegWrite), 32'd0);
      chk("st_hold_WData",  WriteData,     32'h99);

      // Load never acked: timeout after 4 wait cycles; Flush during wait has no effect
      ExValid = 1'b1; ExRegWrite = 1'b1; ExMemRead = 1'b1; ExWriteReg = 5'd3; ExAluResult = 32'h100;
      step(); clear_ex();
      Flush = 1'b1;
      repeat (3) step();
      chk("to_Stall_last", 32'(Stall),    32'd1);
      chk("to_Berr_early", 32'(BusError), 32'd0);
      step();
      chk("to_BusError", 32'(BusError), 32'd1);
      chk("to_Stall",    32'(Stall),    32'd0);
      chk("to_RegWrite", 32'(RegWrite), 32'd0);
      Flush = 1'b0; MemAck = 1'b1; MemRData = 32'hBAD0BAD0;
      step();
      MemAck = 1'b0;
      chk("late_ack_Berr",  32'(BusError), 32'd0);
      chk("late_ack_RW",    32'(RegWrite), 32'd0);
      chk("late_ack_WData", WriteData,     32'h99);

      // Write to r0, then a flushed op
      ExValid = 1'b1; ExRegWrite = 1'b1; ExWriteReg = 5'd0; ExAluResult = 32'hDEAD;
      step();
      chk("r0_RegWrite", 32'(RegWrite), 32'd0);
      ExWriteReg = 5'd6; ExAluResult = 32'h66; Flush = 1'b1;
      step(); clear_ex(); Flush = 1'b0;
      chk("flush_RegWrite", 32'(RegWrite), 32'd0);
      chk("flush_WriteReg", 32'(WriteReg), 32'd9);

      // Asynchronous reset in the middle of a wait
      ExValid = 1'b1; ExRegWrite = 1'b1; ExMemRead = 1'b1; ExWriteReg = 5'd4; ExAluResult = 32'h200;
      step(); clear_ex();
      chk("arst_pre_Stall", 32'(Stall), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_MemReq",   32'(MemReq),   32'd0);
      chk("arst_Stall",    32'(Stall),    32'd0);
      chk("arst_RegWrite", 32'(RegWrite), 32'd0);
      chk("arst_MemAddr",  MemAddr,       32'd0);
      step();
      rst_n = 1'b1;
      ExValid = 1'b1; ExRegWrite = 1'b1; ExWriteReg = 5'd2; ExAluResult = 32'h22;
      step(); clear_ex();
      chk("post_rst_RegWrite",  32'(RegWrite), 32'd1);
      chk("post_rst_WriteData", WriteData,     32'h22);

      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
